// File: rtl/psw_pkg.sv
// Shared constants and sizing helper for the push-switch debounce slice.
package psw_pkg;

  localparam int PSW_N_SW         = 20;
  localparam int PSW_TICK_DIV     = 50000;
  localparam int PSW_STABLE_TICKS = 8;

  // Stability counter only needs to hold 0..STABLE_TICKS-1.
  function automatic int psw_cnt_w(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

  localparam int PSW_CNT_W = psw_cnt_w(PSW_STABLE_TICKS);

endpackage

// File: rtl/psw_debounce_bit.sv
// One switch line: two-flop synchroniser, tick-qualified stability filter,
// registered press/release pulses and a clearable press latch.
module psw_debounce_bit
  import psw_pkg::*;
#(
  parameter int STABLE_TICKS = PSW_STABLE_TICKS
) (
  input  logic CLK,
  input  logic RST,
  input  logic sw_in,
  input  logic tick,
  input  logic sticky_clr,
  output logic level,
  output logic press,
  output logic rel,
  output logic sticky
);

  localparam int CNT_W = psw_cnt_w(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync_meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      level_d   <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      sync_meta <= sw_in;
      sync      <= sync_meta;

      // Any cycle that agrees with the accepted level restarts qualification.
      if (sync == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          level <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      level_d <= level;
      press   <= level & ~level_d;
      rel     <= ~level & level_d;
      // A press in the same cycle as a clear keeps the latch set.
      sticky  <= press | (sticky & ~sticky_clr);
    end
  end

endmodule

// File: rtl/psw_debounce.sv
// Push-switch conditioning: polarity fix, shared sample-tick prescaler and
// one debounce filter per switch line.
module psw_debounce
  import psw_pkg::*;
#(
  parameter int N_SW         = PSW_N_SW,
  parameter int TICK_DIV     = PSW_TICK_DIV,
  parameter int STABLE_TICKS = PSW_STABLE_TICKS,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_SW-1:0] SW_RAW,
  input  logic [N_SW-1:0] STICKY_CLR,
  output logic [N_SW-1:0] SW_LEVEL,
  output logic [N_SW-1:0] SW_PRESS,
  output logic [N_SW-1:0] SW_RELEASE,
  output logic [N_SW-1:0] SW_STICKY,
  output logic            TICK
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0] pre_cnt;
  logic [N_SW-1:0]  sw_in;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= '0;
    end else if (TICK) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign TICK  = (pre_cnt == PRE_LAST);
  // Internally a 1 always means pressed.
  assign sw_in = SW_RAW ^ {N_SW{POL}};

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    psw_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .CLK       (CLK),
      .RST       (RST),
      .sw_in     (sw_in[i]),
      .tick      (TICK),
      .sticky_clr(STICKY_CLR[i]),
      .level     (SW_LEVEL[i]),
      .press     (SW_PRESS[i]),
      .rel       (SW_RELEASE[i]),
      .sticky    (SW_STICKY[i])
    );
  end

endmodule

// File: tb/tb_psw_debounce.sv
// Bench for psw_debounce: cycle-by-cycle reference model plus directed corner sequences.
module tb_psw_debounce;

  localparam int N = 20;
  localparam int D = 4;
  localparam int S = 3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] sw_raw, sticky_clr;
  logic [N-1:0] sw_level, sw_press, sw_release, sw_sticky;
  logic         tick;
  logic [N-1:0] raw_b, clr_b;
  logic [N-1:0] level_b, press_b, release_b, sticky_b;
  logic         tick_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] raw;
    int           hold;
    logic [N-1:0] exp_level;
  } vec_t;
  vec_t vecs[11];

  // Reference model: cycles since reset, recent raw history, per-bit last agree/accept cycle.
  int           m_t;
  logic [N-1:0] m_q[$];
  int           m_anchor[N];
  logic [N-1:0] m_lvl, m_lvl_prev, m_press, m_rel, m_sticky;

  always #5 CLK = ~CLK;

  psw_debounce #(.N_SW(N), .TICK_DIV(D), .STABLE_TICKS(S), .ACTIVE_LOW(0)) u_dut (
    .CLK(CLK), .RST(RST), .SW_RAW(sw_raw), .STICKY_CLR(sticky_clr),
    .SW_LEVEL(sw_level), .SW_PRESS(sw_press), .SW_RELEASE(sw_release),
    .SW_STICKY(sw_sticky), .TICK(tick)
  );

  psw_debounce #(.N_SW(N), .TICK_DIV(D), .STABLE_TICKS(S), .ACTIVE_LOW(1)) u_dut_al (
    .CLK(CLK), .RST(RST), .SW_RAW(raw_b), .STICKY_CLR(clr_b),
    .SW_LEVEL(level_b), .SW_PRESS(press_b), .SW_RELEASE(release_b),
    .SW_STICKY(sticky_b), .TICK(tick_b)
  );

  function automatic void check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_rng(string name, int v, int lo, int hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endfunction

  function automatic void model_reset();
    m_t = 0;
    m_q.delete();
    m_lvl = '0; m_lvl_prev = '0; m_press = '0; m_rel = '0; m_sticky = '0;
    for (int i = 0; i < N; i++) m_anchor[i] = -1;
  endfunction

  // Level flips once S ticks have fallen inside an unbroken run of disagreement.
  function automatic void model_step(logic rst, logic [N-1:0] raw, logic [N-1:0] clr);
    logic [N-1:0] sync, nl;
    logic         tk;
    if (rst) begin
      model_reset();
      return;
    end
    sync = (m_q.size() >= 2) ? m_q[m_q.size()-2] : '0;
    tk   = (m_t % D) == D - 1;
    nl   = m_lvl;
    for (int i = 0; i < N; i++) begin
      if (sync[i] == m_lvl[i]) begin
        m_anchor[i] = m_t;
      end else if (tk && ((m_t + 1) / D - (m_anchor[i] + 1) / D) == S) begin
        nl[i]       = sync[i];
        m_anchor[i] = m_t;
      end
    end
    m_q.push_back(raw);
    if (m_q.size() > 2) void'(m_q.pop_front());
    m_sticky   = m_press | (m_sticky & ~clr);
    m_press    = m_lvl & ~m_lvl_prev;
    m_rel      = ~m_lvl & m_lvl_prev;
    m_lvl_prev = m_lvl;
    m_lvl      = nl;
    m_t++;
  endfunction

  task automatic cycle();
    logic exp_tick;
    model_step(RST, sw_raw, sticky_clr);
    @(posedge CLK);
    #1;
    exp_tick = (m_t % D) == D - 1;
    check("level",   sw_level,   m_lvl);
    check("press",   sw_press,   m_press);
    check("release", sw_release, m_rel);
    check("sticky",  sw_sticky,  m_sticky);
    check("tick",    N'(tick),   N'(exp_tick));
    check("tick_al", N'(tick_b), N'(exp_tick));
  endtask

  task automatic wait_lvl(input logic [N-1:0] mask, input logic [N-1:0] val, output int n);
    n = 0;
    while ((((sw_level ^ val) & mask) != '0) && n < 40) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    int n, np, nr, cnt_bad;

    vecs[0]  = '{20'h00000, 20, 20'h00000};
    vecs[1]  = '{20'hFFFFF,  6, 20'h00000};
    vecs[2]  = '{20'h00000, 20, 20'h00000};
    vecs[3]  = '{20'hA5A5A, 16, 20'hA5A5A};
    vecs[4]  = '{20'h5A5A5,  8, 20'hA5A5A};
    vecs[5]  = '{20'h5A5A5, 16, 20'h5A5A5};
    vecs[6]  = '{20'hF0F0F, 16, 20'hF0F0F};
    vecs[7]  = '{20'h00001, 16, 20'h00001};
    vecs[8]  = '{20'h80000, 16, 20'h80000};
    vecs[9]  = '{20'h00000, 10, 20'h80000};
    vecs[10] = '{20'h00000,  6, 20'h00000};

    sw_raw = '1; sticky_clr = '0; raw_b = '1; clr_b = '0; RST = 1'b1;
    model_reset();

    // Reset with every switch held
    repeat (3) begin
      cycle();
      check("rst_outputs_zero", sw_level | sw_press | sw_release | sw_sticky, '0);
    end
    RST = 1'b0;
    wait_lvl('1, '1, n);
    check_rng("rst_exit_latency", n, 11, 14);
    cycle();
    check("rst_exit_press", sw_press, '1);
    cycle();
    check("rst_exit_press_end", sw_press, '0);
    check("rst_exit_sticky", sw_sticky, '1);

    sw_raw = '0;
    repeat (16) cycle();
    sticky_clr = '1;
    cycle();
    sticky_clr = '0;
    check("sticky_bulk_clear", sw_sticky, '0);

    // Clean press on bit 0
    sw_raw[0] = 1'b1;
    wait_lvl(20'h00001, 20'h00001, n);
    check_rng("press0_latency", n, 11, 14);
    np = 0; nr = 0; cnt_bad = 0;
    repeat (16) begin
      cycle();
      np += int'(sw_press[0]);
      if (sw_release != '0) nr++;
      if ((sw_level & ~20'h00001) != '0) cnt_bad++;
    end
    check_rng("press0_pulse_count", np, 1, 1);
    check_rng("press0_no_release", nr, 0, 0);
    check_rng("press0_others_quiet", cnt_bad, 0, 0);

    // Bounce on bit 5
    cnt_bad = 0;
    for (int k = 0; k < 14; k++) begin
      sw_raw[5] = ~k[0];
      repeat (3) begin
        cycle();
        if (sw_level[5]) cnt_bad++;
      end
    end
    check_rng("bounce_no_level", cnt_bad, 0, 0);
    sw_raw[5] = 1'b1;
    wait_lvl(20'h00020, 20'h00020, n);
    check_rng("bounce_settle_latency", n, 11, 14);
    repeat (3) cycle();

    // Release keeps the latch, explicit clear drops it
    sw_raw[5] = 1'b0;
    nr = 0;
    repeat (20) begin
      cycle();
      nr += int'(sw_release[5]);
    end
    check_rng("release5_pulse_count", nr, 1, 1);
    check("release5_sticky_held", N'(sw_sticky[5]), N'(1));
    sticky_clr[5] = 1'b1;
    cycle();
    sticky_clr[5] = 1'b0;
    check("release5_sticky_cleared", N'(sw_sticky[5]), N'(0));

    // Set/clear collision on bit 7
    sticky_clr[7] = 1'b1;
    sw_raw[7] = 1'b1;
    n = 0;
    while (!sw_press[7] && n < 30) begin
      cycle();
      n++;
    end
    check_rng("coll_press_latency", n, 12, 15);
    cycle();
    check("coll_sticky_set_wins", N'(sw_sticky[7]), N'(1));
    cycle();
    check("coll_sticky_cleared", N'(sw_sticky[7]), N'(0));
    sticky_clr[7] = 1'b0;

    sw_raw = '0;
    sticky_clr = '1;
    repeat (20) cycle();
    sticky_clr = '0;

    // Table-driven hold/glitch vectors
    for (int k = 0; k < 11; k++) begin
      sw_raw = vecs[k].raw;
      repeat (vecs[k].hold) cycle();
      check($sformatf("vec%0d_level", k), sw_level, vecs[k].exp_level);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 19) == 0) sw_raw[i] = ~sw_raw[i];
      sticky_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      cycle();
    end
    RST = 1'b0;
    sticky_clr = '0;

    // Active-low instance: reset mid-qualification
    raw_b[19] = 1'b0;
    cnt_bad = 0;
    repeat (6) begin
      cycle();
      if ((level_b | press_b) != '0) cnt_bad++;
    end
    check_rng("pol_pre_reset_quiet", cnt_bad, 0, 0);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    check("pol_rst_cleared", level_b | press_b | sticky_b, '0);
    n = 0;
    while (!level_b[19] && n < 40) begin
      cycle();
      n++;
    end
    check_rng("pol_latency", n, 11, 14);
    check("pol_level", level_b, 20'h80000);
    cycle();
    check("pol_press", press_b, 20'h80000);
    cycle();
    check("pol_sticky", sticky_b, 20'h80000);
    check("pol_no_release", release_b, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
